// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: buffers retiring results and drives the regfile write port.
// Optional REGFILE_WB_FORWARD_EN adds a youngest-pending-write lookup for decode.
module regfile_wb_ctrl #(
  parameter int n     = 32,
  parameter int r     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [r-1:0]               in_rd,
  input  logic [n-1:0]               in_data,
  input  logic                       in_jal,
  input  logic [n-1:0]               in_pcplus4,
  output logic                       we3,
  output logic [r-1:0]               wa3,
  output logic [n-1:0]               wd3,
  output logic [2**r-1:0]            busy,
`ifdef REGFILE_WB_FORWARD_EN
  input  logic [r-1:0]               fwd_ra1,
  input  logic [r-1:0]               fwd_ra2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [n-1:0]               fwd_data1,
  output logic [n-1:0]               fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [r-1:0]    q_dst [DEPTH];
  logic [n-1:0]    q_dat [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     cnt;
  logic            init_q;

  logic [r-1:0]    dst_eff;
  logic [n-1:0]    dat_eff;
  logic            push;
  logic            pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign in_ready = init_q && !full;

  // jal always targets the link register regardless of in_rd
  assign dst_eff = in_jal ? r'(31) : in_rd;
  assign dat_eff = in_jal ? in_pcplus4 : in_data;
  assign push    = in_valid && in_ready && (dst_eff != '0);
  assign pop     = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      q_vld  <= '0;
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
    end else begin
      init_q <= 1'b1;
      if (pop) begin
        we3           <= 1'b1;
        wa3           <= q_dst[rd_ptr];
        wd3           <= q_dat[rd_ptr];
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end else begin
        we3 <= 1'b0;
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_dst[wr_ptr] <= dst_eff;
      q_dat[wr_ptr] <= dat_eff;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q_vld[i]) busy[q_dst[i]] = 1'b1;
    if (we3) busy[wa3] = 1'b1;
    busy[0] = 1'b0;
  end

`ifdef REGFILE_WB_FORWARD_EN
  typedef struct packed {
    logic         hit;
    logic [n-1:0] data;
  } fwd_t;

  // Scan oldest to youngest so the youngest match overrides
  function automatic fwd_t lookup(input logic [r-1:0] ra);
    fwd_t          f;
    logic [AW-1:0] idx;
    f = '0;
    if (we3 && wa3 == ra) begin
      f.hit  = 1'b1;
      f.data = wd3;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (q_vld[idx] && q_dst[idx] == ra) begin
        f.hit  = 1'b1;
        f.data = q_dat[idx];
      end
    end
    if (ra == '0) f = '0;
    return f;
  endfunction

  fwd_t f1;
  fwd_t f2;

  always_comb begin
    f1 = lookup(fwd_ra1);
    f2 = lookup(fwd_ra2);
  end

  assign fwd_hit1  = f1.hit;
  assign fwd_data1 = f1.data;
  assign fwd_hit2  = f2.hit;
  assign fwd_data2 = f2.data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: queue of in-flight writes vs DUT port.
// Honours REGFILE_WB_FORWARD_EN when defined.
module tb_regfile_wb_ctrl;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        in_jal;
  logic [31:0] in_pcplus4;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef REGFILE_WB_FORWARD_EN
  logic [4:0]  fwd_ra1, fwd_ra2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  wr_t exp_q[$];
  logic [31:0] ref_rf [32];
  logic [31:0] dut_rf [32];

  regfile_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data),
    .in_jal(in_jal), .in_pcplus4(in_pcplus4),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy),
`ifdef REGFILE_WB_FORWARD_EN
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pending set is exactly the queue, head shown on the port
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [31:0] eb;
      int          pend;
      wr_t         h;
      eb = '0;
      foreach (exp_q[i]) eb[exp_q[i].a] = 1'b1;
      pend = exp_q.size() - (we3 ? 1 : 0);
      chk("busy", busy, eb);
      chk("count", 32'(count), 32'(pend));
      chk("empty", 32'(empty), 32'(pend == 0));
      chk("full", 32'(full), 32'(pend == 4));
      chk("in_ready", 32'(in_ready), 32'(pend < 4));
      if (we3) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we3", 32'(we3), 32'd0);
        end else begin
          h = exp_q.pop_front();
          chk("wa3", 32'(wa3), 32'(h.a));
          chk("wd3", wd3, h.d);
          dut_rf[wa3] = wd3;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [4:0] rd,
                       input logic [31:0] d, input bit j,
                       input logic [31:0] pc);
    bit         rdy;
    logic [4:0] a;
    in_valid = v; in_rd = rd; in_data = d;
    in_jal = j; in_pcplus4 = pc;
    rdy = in_ready;
    @(posedge clk);
    if (v && rdy) begin
      a = j ? 5'd31 : rd;
      if (a != 0) begin
        exp_q.push_back('{a, j ? pc : d});
        ref_rf[a] = j ? pc : d;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) drive(0, 5'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic clear_models();
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      ref_rf[i] = '0;
      dut_rf[i] = '0;
    end
  endtask

  initial begin
    int w;
    in_valid = 0; in_rd = 0; in_data = 0;
    in_jal = 0; in_pcplus4 = 0;
`ifdef REGFILE_WB_FORWARD_EN
    fwd_ra1 = 0; fwd_ra2 = 0;
`endif
    clear_models();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wa3", 32'(wa3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1;
    #1 chk("ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_post_edge", 32'(in_ready), 32'd1);
    mon_en = 1;

    // Single write timing
    drive(1, 5'd5, 32'hDEADBEEF, 0, 32'd0);
    chk("sw_busy_k", 32'(busy[5]), 32'd1);
    chk("sw_we3_k", 32'(we3), 32'd0);
    idle(1);
    chk("sw_we3_k1", 32'(we3), 32'd1);
    chk("sw_wa3_k1", 32'(wa3), 32'd5);
    chk("sw_wd3_k1", wd3, 32'hDEADBEEF);
    idle(1);
    chk("sw_busy_k2", 32'(busy[5]), 32'd0);
    chk("sw_we3_k2", 32'(we3), 32'd0);

    // jal forces link register
    drive(1, 5'd3, 32'h55, 1, 32'h00400010);
    chk("jal_busy3", 32'(busy[3]), 32'd0);
    chk("jal_busy31", 32'(busy[31]), 32'd1);
    idle(1);
    chk("jal_wa3", 32'(wa3), 32'd31);
    chk("jal_wd3", wd3, 32'h00400010);
    idle(1);

    // r0 write dropped after handshake
    chk("r0_ready", 32'(in_ready), 32'd1);
    drive(1, 5'd0, 32'h1234, 0, 32'd0);
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_busy", busy, 32'd0);
    idle(3);

    // Back-to-back burst, order checked by scoreboard
    for (int i = 0; i < 8; i++)
      drive(1, 5'(i + 8), 32'h100 + 32'(i), 0, 32'd0);
    idle(3);

`ifdef REGFILE_WB_FORWARD_EN
    fwd_ra1 = 5'd7; fwd_ra2 = 5'd0;
    drive(1, 5'd7, 32'd1, 0, 32'd0);
    drive(1, 5'd7, 32'd2, 0, 32'd0);
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_data1", fwd_data1, 32'd2);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    chk("fwd_data2", fwd_data2, 32'd0);
    idle(1);
    chk("fwd_busy7_mid", 32'(busy[7]), 32'd1);
    idle(1);
    chk("fwd_busy7_end", 32'(busy[7]), 32'd0);
`endif

    // Reset mid-stream
    drive(1, 5'd1, 32'hA1, 0, 32'd0);
    drive(1, 5'd2, 32'hA2, 0, 32'd0);
    drive(1, 5'd3, 32'hA3, 0, 32'd0);
    #2 mon_en = 0;
    rst_n = 0;
    #1;
    chk("mid_we3", 32'(we3), 32'd0);
    chk("mid_busy", busy, 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    clear_models();
    @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    mon_en = 1;
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom),
            $urandom, $urandom_range(0, 6) == 0, $urandom);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk("rf_final", dut_rf[i], ref_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
